// File: rtl/decoder_scan_n.sv
// decoder_scan_n -- registered N-to-2^N one-hot decoder with enable and a
// scan mode that steps through the outputs on its own, holding each output
// for DWELL clocks.
//
// Optional feature: define DECODER_SKIP_EN to add the skip[OUTS-1:0] input.
// Scan steps, scan entry and loads then pass over indices whose skip bit is set.
// Direct decode of a skipped index gives the idle value with valid low.
//
// Parameters:
//   N          select width, legal range 1..6; Out is 2**N bits wide
//   DWELL      clocks each output stays active in scan mode (>= 1)
//   ACTIVE_LOW 1: Out is inverted after the register, so the idle value is all ones
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   E      in   enable; 0 forces IDLE
//   mode   in   0 = direct decode, 1 = scan
//   In     in   direct select / scan entry and load index
//   load   in   in scan mode, restart the scan at In
//   skip   in   (DECODER_SKIP_EN only) indices the scan passes over
//   Out    out  one-hot decode, polarity set by ACTIVE_LOW
//   Idx    out  index currently shown on Out
//   valid  out  Out carries a live one-hot value
//   wrap   out  one-cycle pulse when the scan wraps back to the start
module decoder_scan_n #(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                E,
    input  logic                mode,
    input  logic [N-1:0]        In,
    input  logic                load,
`ifdef DECODER_SKIP_EN
    input  logic [(1<<N)-1:0]   skip,
`endif
    output logic [(1<<N)-1:0]   Out,
    output logic [N-1:0]        Idx,
    output logic                valid,
    output logic                wrap
);

    localparam int OUTS = 1 << N;
    localparam int CW   = $clog2(DWELL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t          state_q, state_d;
    logic [OUTS-1:0] out_q, out_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;

    function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] sel);
        logic [OUTS-1:0] r;
        r      = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

`ifdef DECODER_SKIP_EN
    // First index at or circularly after 'start' whose skip bit is clear.
    // Callers guarantee at least one bit is clear.
    function automatic logic [N-1:0] next_free(input logic [N-1:0] start,
                                               input logic [OUTS-1:0] sk);
        logic [N-1:0] r;
        logic [N-1:0] c;
        logic         found;
        r     = start;
        found = 1'b0;
        for (int k = 0; k < OUTS; k++) begin
            c = start + k[N-1:0];
            if (!found && !sk[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;

        if (!E) begin
            // Idx keeps its last value; the dwell is discarded so the next entry starts fresh.
            state_d = IDLE;
            out_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (!mode) begin
            state_d = DIRECT;
            idx_d   = In;
            cnt_d   = '0;
            out_d   = onehot(In);
            valid_d = 1'b1;
`ifdef DECODER_SKIP_EN
            if (skip[In]) begin
                out_d   = '0;
                valid_d = 1'b0;
            end
`endif
        end else begin
            state_d = SCAN;
`ifdef DECODER_SKIP_EN
            if (&skip) begin
                // Nothing to show: go dark but keep position and dwell.
                out_d   = '0;
                valid_d = 1'b0;
            end else begin
                if (state_q != SCAN || load) begin
                    idx_d = next_free(In, skip);
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    idx_d  = next_free(N'(idx_q + 1'b1), skip);
                    cnt_d  = '0;
                    wrap_d = (idx_d <= idx_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                out_d   = onehot(idx_d);
                valid_d = 1'b1;
            end
`else
            // Entry and load both win over a step due on the same cycle.
            if (state_q != SCAN || load) begin
                idx_d = In;
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                idx_d  = N'(idx_q + 1'b1);
                cnt_d  = '0;
                wrap_d = &idx_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            out_d   = onehot(idx_d);
            valid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    // Polarity is applied after the register, so reset and idle both read as all ones when active-low.
    assign Out   = (ACTIVE_LOW != 0) ? ~out_q : out_q;
    assign Idx   = idx_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Testbench for decoder_scan_n (N=3, DWELL=2). Two instances share inputs:
// one active-high, one active-low. Expected values are hand-computed in the
// vector table and in the short sequences for reset and skip behaviour.
module tb_decoder_scan_n;

    logic       clk;
    logic       rst_n;
    logic       E;
    logic       mode;
    logic [2:0] In;
    logic       load;
`ifdef DECODER_SKIP_EN
    logic [7:0] skip;
`endif
    logic [7:0] out_h, out_l;
    logic [2:0] idx_h, idx_l;
    logic       valid_h, valid_l;
    logic       wrap_h, wrap_l;

    int checks   = 0;
    int failures = 0;

    decoder_scan_n #(.N(3), .DWELL(2), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst_n(rst_n), .E(E), .mode(mode), .In(In), .load(load),
`ifdef DECODER_SKIP_EN
        .skip(skip),
`endif
        .Out(out_h), .Idx(idx_h), .valid(valid_h), .wrap(wrap_h)
    );

    decoder_scan_n #(.N(3), .DWELL(2), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .E(E), .mode(mode), .In(In), .load(load),
`ifdef DECODER_SKIP_EN
        .skip(skip),
`endif
        .Out(out_l), .Idx(idx_l), .valid(valid_l), .wrap(wrap_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       e;
        logic       mode;
        logic [2:0] in;
        logic       load;
        logic [7:0] out;
        logic [2:0] idx;
        logic       valid;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic m, input logic [2:0] in, input logic ld,
                       input logic [7:0] out, input logic [2:0] idx, input logic v, input logic w);
        vec_t t;
        t.e = e; t.mode = m; t.in = in; t.load = ld;
        t.out = out; t.idx = idx; t.valid = v; t.wrap = w;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Check both instances against one expected active-high state.
    task automatic chk_all(input string nm, input logic [7:0] out, input logic [2:0] idx,
                           input logic v, input logic w);
        chk({nm, ".out"},   out_h, out);
        chk({nm, ".idx"},   {5'b0, idx_h}, {5'b0, idx});
        chk({nm, ".valid"}, {7'b0, valid_h}, {7'b0, v});
        chk({nm, ".wrap"},  {7'b0, wrap_h}, {7'b0, w});
        chk({nm, ".out_al"},   out_l, ~out);
        chk({nm, ".idx_al"},   {5'b0, idx_l}, {5'b0, idx});
        chk({nm, ".valid_al"}, {7'b0, valid_l}, {7'b0, v});
        chk({nm, ".wrap_al"},  {7'b0, wrap_l}, {7'b0, w});
    endtask

    initial begin
        rst_n = 1'b0; E = 1'b0; mode = 1'b0; In = 3'd5; load = 1'b0;
`ifdef DECODER_SKIP_EN
        skip = 8'h00;
`endif

        //     E  m  In  ld  Out    Idx v  w
        add(0, 0, 5, 0, 8'h00, 0, 0, 0);   // idle after reset
        for (int k = 0; k < 8; k++)
            add(1, 0, 3'(k), 0, 8'(1 << k), 3'(k), 1, 0);   // direct sweep
        add(1, 1, 6, 0, 8'h40, 6, 1, 0);   // scan entry, cnt=0
        add(1, 1, 6, 0, 8'h40, 6, 1, 0);   // cnt=1
        add(1, 1, 6, 0, 8'h80, 7, 1, 0);   // step
        add(1, 1, 6, 0, 8'h80, 7, 1, 0);
        add(1, 1, 6, 0, 8'h01, 0, 1, 1);   // wrap 7->0
        add(1, 1, 6, 0, 8'h01, 0, 1, 0);   // wrap lasts one cycle
        add(1, 1, 6, 0, 8'h02, 1, 1, 0);
        add(1, 1, 6, 0, 8'h02, 1, 1, 0);   // step due next edge
        add(1, 1, 3, 1, 8'h08, 3, 1, 0);   // load overrides step
        add(1, 1, 3, 0, 8'h08, 3, 1, 0);   // full dwell after load
        add(1, 1, 3, 0, 8'h10, 4, 1, 0);
        add(0, 1, 3, 0, 8'h00, 4, 0, 0);   // E=0 mid-scan, Idx holds
        add(0, 0, 1, 0, 8'h00, 4, 0, 0);
        add(1, 1, 5, 0, 8'h20, 5, 1, 0);   // re-entry from IDLE uses In
        add(1, 0, 2, 0, 8'h04, 2, 1, 0);   // to direct
        add(1, 1, 7, 0, 8'h80, 7, 1, 0);   // re-entry from DIRECT uses In
        add(1, 1, 7, 0, 8'h80, 7, 1, 0);
        add(1, 0, 1, 1, 8'h02, 1, 1, 0);   // load ignored in direct
        add(1, 1, 2, 1, 8'h04, 2, 1, 0);   // entry with load set
        add(1, 1, 2, 1, 8'h04, 2, 1, 0);   // load holds the index

        #12;
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            E = vecs[i].e; mode = vecs[i].mode; In = vecs[i].in; load = vecs[i].load;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].idx, vecs[i].valid, vecs[i].wrap);
        end

        // Asynchronous reset in the middle of a scan.
        E = 1'b1; mode = 1'b1; In = 3'd6; load = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("post_rst_entry", 8'h40, 3'd6, 1'b1, 1'b0);

`ifdef DECODER_SKIP_EN
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        skip = 8'b0110_0000; In = 3'd4;
        @(posedge clk); #1; chk_all("skip0", 8'h10, 3'd4, 1'b1, 1'b0);
        @(posedge clk); #1; chk_all("skip1", 8'h10, 3'd4, 1'b1, 1'b0);
        @(posedge clk); #1; chk_all("skip2", 8'h80, 3'd7, 1'b1, 1'b0);
        @(posedge clk); #1; chk_all("skip3", 8'h80, 3'd7, 1'b1, 1'b0);
        @(posedge clk); #1; chk_all("skip4", 8'h01, 3'd0, 1'b1, 1'b1);
        skip = 8'hFF;
        @(posedge clk); #1; chk_all("skip_all", 8'h00, 3'd0, 1'b0, 1'b0);
        skip = 8'h00; mode = 1'b0; In = 3'd3;
        @(posedge clk); #1; chk_all("skip_dir_ok", 8'h08, 3'd3, 1'b1, 1'b0);
        skip = 8'h08;
        @(posedge clk); #1; chk_all("skip_dir_sk", 8'h00, 3'd3, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
